// File: rtl/branch_redirect_unit.sv
// Execute-stage control-transfer resolver: evaluates JAL/JALR/branches,
// issues a registered one-cycle redirect to fetch, squashes the wrong-path
// instructions for a programmable window and produces the JAL/JALR link value.
module branch_redirect_unit #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_TARGET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_branch,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        JumpFlag,
  output logic [31:0] JumpAddr,
  output logic        squash,
  output logic        link_valid,
  output logic [31:0] link_data,
  output logic        misalign_err,
  output logic        illegal_br,
  output logic [31:0] taken_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  // Counter preload for the FLUSH phase; unused when the window is one cycle.
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      state;
  logic [3:0]  flush_cnt;

  logic        accept;
  logic        sel_jal;
  logic        sel_jalr;
  logic        sel_br;
  logic        br_cond;
  logic        br_reserved;
  logic        taken;
  logic [31:0] target;

  // Anything arriving while a redirect or flush is in progress is wrong-path.
  assign squash = valid_in & (state != IDLE);
  assign accept = valid_in & ~squash;

  // Class decode with priority JAL > JALR > branch.
  assign sel_jal  = is_jal;
  assign sel_jalr = ~is_jal & is_jalr;
  assign sel_br   = ~is_jal & ~is_jalr & is_branch;

  // Branch condition, target and taken decision.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first so no path leaves a value unassigned (which would infer a latch).
  always_comb begin
    br_cond     = 1'b0;
    br_reserved = 1'b0;
    case (funct3)
      3'b000:  br_cond = (rs1_data == rs2_data);
      3'b001:  br_cond = (rs1_data != rs2_data);
      3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_cond = (rs1_data <  rs2_data);
      3'b111:  br_cond = (rs1_data >= rs2_data);
      default: br_reserved = 1'b1;
    endcase

    target = pc_in + imm;
    if (sel_jalr) begin
      target = (rs1_data + imm) & ~32'h1;
    end

    taken = sel_jal | sel_jalr | (sel_br & br_cond);
  end

  // Redirect FSM with registered redirect, link, error and counter outputs.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      flush_cnt    <= 4'd0;
      JumpFlag     <= 1'b0;
      JumpAddr     <= RESET_TARGET;
      link_valid   <= 1'b0;
      link_data    <= 32'd0;
      misalign_err <= 1'b0;
      illegal_br   <= 1'b0;
      taken_count  <= 32'd0;
    end else begin
      JumpFlag     <= 1'b0;
      link_valid   <= 1'b0;
      misalign_err <= accept & taken & target[1];
      illegal_br   <= accept & sel_br & br_reserved;

      if (accept && (sel_jal || sel_jalr) && !target[1]) begin
        link_valid <= 1'b1;
        link_data  <= pc_in + 32'd4;
      end

      case (state)
        IDLE: begin
          if (accept && taken && !target[1]) begin
            state       <= REDIRECT;
            JumpFlag    <= 1'b1;
            JumpAddr    <= target;
            taken_count <= taken_count + 32'd1;
          end
        end
        REDIRECT: begin
          flush_cnt <= FLUSH_LOAD;
          state     <= (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed self-checking bench for branch_redirect_unit (FLUSH_CYCLES = 2).
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] pc_in;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        JumpFlag;
  logic [31:0] JumpAddr;
  logic        squash;
  logic        link_valid;
  logic [31:0] link_data;
  logic        misalign_err;
  logic        illegal_br;
  logic [31:0] taken_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_redirect_unit #(.FLUSH_CYCLES(2), .RESET_TARGET(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_branch(is_branch), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .JumpFlag(JumpFlag), .JumpAddr(JumpAddr), .squash(squash),
    .link_valid(link_valid), .link_data(link_data),
    .misalign_err(misalign_err), .illegal_br(illegal_br), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_in = 1'b0; pc_in = 32'h0; is_jal = 1'b0; is_jalr = 1'b0; is_branch = 1'b0;
    funct3 = 3'b000; rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    clr();
    valid_in = 1'b1; is_branch = 1'b1; funct3 = f3; pc_in = pc;
    rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic drive_jal(input logic [31:0] pc, input logic [31:0] im);
    clr();
    valid_in = 1'b1; is_jal = 1'b1; pc_in = pc; imm = im;
  endtask

  task automatic drive_jalr(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] im);
    clr();
    valid_in = 1'b1; is_jalr = 1'b1; pc_in = pc; rs1_data = a; imm = im;
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0;
    repeat (3) tick();
    valid_in = 1'b1;
    #1;
    total_cnt++; if (JumpFlag !== 1'b0) $display("FAIL rst_jumpflag got %b want 0", JumpFlag); else pass_cnt++;
    total_cnt++; if (JumpAddr !== 32'h0) $display("FAIL rst_jumpaddr got %h want 0", JumpAddr); else pass_cnt++;
    total_cnt++; if (link_valid !== 1'b0 || link_data !== 32'h0) $display("FAIL rst_link got %b/%h want 0/0", link_valid, link_data); else pass_cnt++;
    total_cnt++; if (misalign_err !== 1'b0 || illegal_br !== 1'b0) $display("FAIL rst_errs got %b%b want 00", misalign_err, illegal_br); else pass_cnt++;
    total_cnt++; if (taken_count !== 32'h0) $display("FAIL rst_count got %h want 0", taken_count); else pass_cnt++;
    total_cnt++; if (squash !== 1'b0) $display("FAIL rst_squash got %b want 0", squash); else pass_cnt++;
    clr();
    rst_n = 1'b1;
    tick();
    drive_br(3'b000, 32'h10, 32'd5, 32'd5, 32'h30);
    tick();
    total_cnt++; if (JumpFlag !== 1'b1) $display("FAIL beq_flag got %b want 1", JumpFlag); else pass_cnt++;
    total_cnt++; if (JumpAddr !== 32'h40) $display("FAIL beq_addr got %h want 40", JumpAddr); else pass_cnt++;
    total_cnt++; if (taken_count !== 32'd1) $display("FAIL beq_count got %0d want 1", taken_count); else pass_cnt++;
    total_cnt++; if (link_valid !== 1'b0) $display("FAIL beq_link got %b want 0", link_valid); else pass_cnt++;
  endtask

  task automatic test_squash_window();
    // Now in the REDIRECT cycle.
    drive_jal(32'h20, 32'h8);
    #1;
    total_cnt++; if (squash !== 1'b1) $display("FAIL sq1_squash got %b want 1", squash); else pass_cnt++;
    tick();
    total_cnt++; if (JumpFlag !== 1'b0 || link_valid !== 1'b0) $display("FAIL sq1_effect got %b/%b want 0/0", JumpFlag, link_valid); else pass_cnt++;
    drive_jal(32'h24, 32'h8);
    #1;
    total_cnt++; if (squash !== 1'b1) $display("FAIL sq2_squash got %b want 1", squash); else pass_cnt++;
    tick();
    total_cnt++; if (JumpFlag !== 1'b0 || link_valid !== 1'b0) $display("FAIL sq2_effect got %b/%b want 0/0", JumpFlag, link_valid); else pass_cnt++;
    total_cnt++; if (JumpAddr !== 32'h40) $display("FAIL sq_hold_addr got %h want 40", JumpAddr); else pass_cnt++;
    drive_jal(32'h44, 32'h100);
    #1;
    total_cnt++; if (squash !== 1'b0) $display("FAIL sq3_squash got %b want 0", squash); else pass_cnt++;
    tick();
    total_cnt++; if (JumpFlag !== 1'b1 || JumpAddr !== 32'h144) $display("FAIL jal_redirect got %b/%h want 1/144", JumpFlag, JumpAddr); else pass_cnt++;
    total_cnt++; if (link_valid !== 1'b1 || link_data !== 32'h48) $display("FAIL jal_link got %b/%h want 1/48", link_valid, link_data); else pass_cnt++;
    total_cnt++; if (taken_count !== 32'd2) $display("FAIL jal_count got %0d want 2", taken_count); else pass_cnt++;
    idle(1);
    total_cnt++; if (JumpFlag !== 1'b0 || link_valid !== 1'b0 || JumpAddr !== 32'h144) $display("FAIL jal_pulse_end got %b/%b/%h want 0/0/144", JumpFlag, link_valid, JumpAddr); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_jalr();
    drive_jalr(32'h200, 32'h1001, 32'h4);
    #1;
    total_cnt++; if (squash !== 1'b0) $display("FAIL jalr_b2b_squash got %b want 0", squash); else pass_cnt++;
    tick();
    total_cnt++; if (JumpFlag !== 1'b1 || JumpAddr !== 32'h1004) $display("FAIL jalr_redirect got %b/%h want 1/1004", JumpFlag, JumpAddr); else pass_cnt++;
    total_cnt++; if (link_valid !== 1'b1 || link_data !== 32'h204) $display("FAIL jalr_link got %b/%h want 1/204", link_valid, link_data); else pass_cnt++;
    idle(2);
    drive_jalr(32'h280, 32'h1002, 32'h0);
    tick();
    total_cnt++; if (misalign_err !== 1'b1) $display("FAIL mis_pulse got %b want 1", misalign_err); else pass_cnt++;
    total_cnt++; if (JumpFlag !== 1'b0 || link_valid !== 1'b0) $display("FAIL mis_effect got %b/%b want 0/0", JumpFlag, link_valid); else pass_cnt++;
    total_cnt++; if (JumpAddr !== 32'h1004 || taken_count !== 32'd3) $display("FAIL mis_hold got %h/%0d want 1004/3", JumpAddr, taken_count); else pass_cnt++;
    drive_br(3'b001, 32'h300, 32'd1, 32'd2, 32'h10);
    #1;
    total_cnt++; if (squash !== 1'b0) $display("FAIL mis_next_squash got %b want 0", squash); else pass_cnt++;
    tick();
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL mis_one_cycle got %b want 0", misalign_err); else pass_cnt++;
    total_cnt++; if (JumpFlag !== 1'b1 || JumpAddr !== 32'h310 || taken_count !== 32'd4) $display("FAIL bne_redirect got %b/%h/%0d want 1/310/4", JumpFlag, JumpAddr, taken_count); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_signed_unsigned();
    drive_br(3'b100, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h20);
    tick();
    total_cnt++; if (JumpFlag !== 1'b1 || JumpAddr !== 32'h420) $display("FAIL blt_taken got %b/%h want 1/420", JumpFlag, JumpAddr); else pass_cnt++;
    idle(2);
    drive_br(3'b110, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h20);
    tick();
    total_cnt++; if (JumpFlag !== 1'b0 || JumpAddr !== 32'h420 || taken_count !== 32'd5) $display("FAIL bltu_not_taken got %b/%h/%0d want 0/420/5", JumpFlag, JumpAddr, taken_count); else pass_cnt++;
    drive_br(3'b010, 32'h540, 32'd7, 32'd7, 32'h20);
    tick();
    total_cnt++; if (illegal_br !== 1'b1 || JumpFlag !== 1'b0) $display("FAIL illegal_pulse got %b/%b want 1/0", illegal_br, JumpFlag); else pass_cnt++;
    idle(1);
    total_cnt++; if (illegal_br !== 1'b0) $display("FAIL illegal_one_cycle got %b want 0", illegal_br); else pass_cnt++;
  endtask

  task automatic test_priority_wrap();
    drive_br(3'b000, 32'h600, 32'd1, 32'd2, 32'h40);
    is_jal = 1'b1;
    tick();
    total_cnt++; if (JumpFlag !== 1'b1 || JumpAddr !== 32'h640) $display("FAIL prio_redirect got %b/%h want 1/640", JumpFlag, JumpAddr); else pass_cnt++;
    total_cnt++; if (link_valid !== 1'b1 || link_data !== 32'h604) $display("FAIL prio_link got %b/%h want 1/604", link_valid, link_data); else pass_cnt++;
    idle(2);
    drive_jal(32'hFFFF_FFF0, 32'h20);
    tick();
    total_cnt++; if (JumpAddr !== 32'h10 || link_data !== 32'hFFFF_FFF4) $display("FAIL wrap got %h/%h want 10/fffffff4", JumpAddr, link_data); else pass_cnt++;
    total_cnt++; if (taken_count !== 32'd7) $display("FAIL wrap_count got %0d want 7", taken_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_flush();
    idle(1);
    // Now in the FLUSH cycle.
    valid_in = 1'b1;
    #1;
    total_cnt++; if (squash !== 1'b1) $display("FAIL flush_squash got %b want 1", squash); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (squash !== 1'b0) $display("FAIL midrst_squash got %b want 0", squash); else pass_cnt++;
    total_cnt++; if (taken_count !== 32'd0 || JumpAddr !== 32'h0) $display("FAIL midrst_regs got %0d/%h want 0/0", taken_count, JumpAddr); else pass_cnt++;
    idle(2);
    rst_n = 1'b1;
    tick();
    drive_br(3'b101, 32'h700, 32'd3, 32'hFFFF_FFFD, 32'h8);
    #1;
    total_cnt++; if (squash !== 1'b0) $display("FAIL post_rst_squash got %b want 0", squash); else pass_cnt++;
    tick();
    total_cnt++; if (JumpFlag !== 1'b1 || JumpAddr !== 32'h708 || taken_count !== 32'd1) $display("FAIL post_rst_redirect got %b/%h/%0d want 1/708/1", JumpFlag, JumpAddr, taken_count); else pass_cnt++;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_squash_window();
    test_jalr();
    test_signed_unsigned();
    test_priority_wrap();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Execute-stage control-transfer resolver that drives the `JumpFlag`/`JumpAddr` redirect into the instruction fetch stage. It evaluates JAL, JALR and conditional branches, computes the target, and issues a registered one-cycle redirect pulse. It then squashes the wrong-path instructions already in flight for a programmable window, and produces the link value for JAL/JALR.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles, starting with the redirect cycle, during which arriving instructions are squashed. Legal range is 1..15.
- `RESET_TARGET`, default 32'h0000_0000: reset value of `JumpAddr`.

Ports:
- `clk`  in  1  — system clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `valid_in`  in  1  — an instruction is present this cycle.
- `pc_in`  in  32  — PC of the presented instruction.
- `is_jal`  in  1  — instruction class is JAL.
- `is_jalr`  in  1  — instruction class is JALR.
- `is_branch`  in  1  — instruction class is conditional branch.
- `funct3`  in  3  — branch condition select.
- `rs1_data`  in  32  — operand 1.
- `rs2_data`  in  32  — operand 2.
- `imm`  in  32  — sign-extended immediate.
- `JumpFlag`  out  1  — registered redirect pulse to fetch.
- `JumpAddr`  out  32  — registered redirect target.
- `squash`  out  1  — combinational; the current `valid_in` instruction is wrong-path.
- `link_valid`  out  1  — registered; `link_data` is to be written to rd.
- `link_data`  out  32  — registered `pc_in + 4`.
- `misalign_err`  out  1  — registered one-cycle pulse on a misaligned taken target.
- `illegal_br`  out  1  — registered one-cycle pulse on a reserved `funct3` value.
- `taken_count`  out  32  — count of issued redirects.

## Operation
- **Instruction acceptance.** An instruction is accepted when `valid_in=1` and `squash=0`.
- **Class priority.** If more than one class bit is set: `is_jal` > `is_jalr` > `is_branch`. If no class bit is set, the instruction is a no-op.
- **Targets.** All sums are modulo 2^32.
  - JAL and branch: `pc_in + imm`.
  - JALR: `(rs1_data + imm) & ~32'h1`.
- **Branch conditions by `funct3`:**
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010 and 011: not taken; `illegal_br` pulses.
- **Taken decision.** JAL and JALR are always taken.
- **Misaligned target.** If a taken target has bit 1 set:
  - no redirect is issued;
  - `misalign_err` pulses;
  - `link_valid` stays 0;
  - the state stays IDLE.
- **Link write.** For an accepted, aligned JAL or JALR: `link_valid=1` and `link_data = pc_in + 4` in the following cycle.
- **State machine:**
  - **IDLE:** an accepted, aligned, taken instruction moves to REDIRECT and loads `JumpAddr` with the target.
  - **REDIRECT:** lasts exactly 1 cycle, with `JumpFlag=1`. Next state is FLUSH if `FLUSH_CYCLES>1`, otherwise IDLE. Loads the flush counter with `FLUSH_CYCLES-2`.
  - **FLUSH:** counts down; returns to IDLE after the count reaches 0.
- **Squash.** `squash = valid_in & (state != IDLE)`.
  - Squashed instructions produce no redirect, no link write and no error pulse, even if they are jumps.
- **Held outputs.** `JumpAddr` holds its last target after the pulse ends.
- **Counter.** `taken_count` increments once per REDIRECT entry and wraps from 0xFFFF_FFFF to 0.
- **Reset values.** `JumpFlag=0`, `JumpAddr=RESET_TARGET`, `link_valid=0`, `link_data=0`, `misalign_err=0`, `illegal_br=0`, `taken_count=0`, state IDLE.
- **Reset mid-operation.** Assertion during REDIRECT or FLUSH returns immediately to IDLE; `squash` drops as soon as reset is asserted.

## Timing
- **Redirect latency.** A taken instruction accepted in cycle N produces `JumpFlag=1` with valid `JumpAddr` during cycle N+1. Fetch samples them at the end of N+1, so PC equals the target in cycle N+2.
- **Squash window.** Cycles N+1 through N+FLUSH_CYCLES. The first instruction accepted again is the one presented in cycle N+FLUSH_CYCLES+1.
- **Output latency.** `link_valid`, `misalign_err` and `illegal_br` are valid in cycle N+1 for an instruction accepted in cycle N. Each is high for exactly 1 cycle per event.
- **Back-to-back.** A taken instruction arriving in cycle N+FLUSH_CYCLES+1 starts a new REDIRECT with no bubble. `JumpFlag` cannot be high in consecutive cycles when `FLUSH_CYCLES≥1`.

## Test plan
- **Reset.** Hold `rst_n=0` for 3 cycles → all outputs at reset values and `JumpAddr=0`. Release, present BEQ with `pc_in=0x10`, `rs1=rs2=5`, `imm=0x30` → `JumpFlag=1` and `JumpAddr=0x40` one cycle later; `taken_count=1`.
- **Squash window.** With `FLUSH_CYCLES=2`, after the above present a JAL in each of the next 2 cycles → `squash=1` on both, no `JumpFlag`, no `link_valid`. A JAL with `pc_in=0x44`, `imm=0x100` in the third cycle → `JumpAddr=0x144`, `link_data=0x48`, `link_valid=1`.
- **JALR.** `rs1=0x1001`, `imm=0x4` → `JumpAddr=0x1004`. `rs1=0x1002`, `imm=0` → `misalign_err` pulse, no `JumpFlag`, `link_valid=0`, next instruction not squashed.
- **Signed vs unsigned.**
  - BLT with `rs1=0xFFFF_FFFF`, `rs2=1` → taken.
  - BLTU with the same operands → not taken.
  - `funct3=010` → `illegal_br` pulse, no redirect.
- **Priority and wrap.**
  - `is_jal=is_branch=1` with the branch condition false → taken as JAL.
  - `pc_in=0xFFFF_FFF0`, `imm=0x20` → `JumpAddr=0x10`.
- **Reset mid-flush.** Assert `rst_n=0` during the FLUSH cycle → state IDLE and `squash=0` immediately. After release, a taken branch redirects normally and `taken_count` restarts from 0.
